sample_decimator: RTL and testbench

Receive-side counterpart of the transmit zero-padding stage in the QAM-16 chain. It takes the upsampled, zero-stuffed sample stream and keeps one sample out of every `factor`, at a selectable phase, and discards the rest. While discarding, it checks that each dropped sample is really zero and counts violations. It sits between the receive matched filter and the symbol demapper.

---
 rtl/sample_decimator_if.sv | 24 ++
 rtl/sample_decimator.sv | 83 ++++++++
 tb/tb_sample_decimator.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_decimator_if.sv
// Sample stream bundle between the matched filter, the decimator and the demapper.
interface sample_decimator_if #(
    parameter int width_data = 16
);
    logic                  en;
    logic                  sync;
    logic [3:0]            phase;
    logic [width_data-1:0] data_in;
    logic [width_data-1:0] data_out;
    logic                  valid_out;
    logic                  ready;
    logic                  zero_err;
    logic [7:0]            err_cnt;

    modport master (
        output en, sync, phase, data_in,
        input  data_out, valid_out, ready, zero_err, err_cnt
    );

    modport slave (
        input  en, sync, phase, data_in,
        output data_out, valid_out, ready, zero_err, err_cnt
    );
endinterface

// File: rtl/sample_decimator.sv
// Keeps one sample per group of `factor` at a selectable phase and
// flags discarded samples that are not zero.
module sample_decimator #(
    parameter int width_data = 16,
    parameter int factor     = 4
) (
    input  logic              clk,
    input  logic              rst,
    sample_decimator_if.slave bus
);
    localparam logic [3:0] LAST = 4'(factor - 1);

    logic [3:0]            cnt_q, cnt_d;
    logic [3:0]            phase_q, phase_d;
    logic [width_data-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ready_q, ready_d;
    logic                  zero_q, zero_d;
    logic [7:0]            err_q, err_d;

    logic [3:0] idx;
    logic [3:0] phaseSel;
    logic [3:0] pe;
    logic       keep;

    // A sync cycle uses the incoming phase and restarts the group at index 0.
    always_comb begin
        idx      = bus.sync ? 4'd0 : cnt_q;
        phaseSel = bus.sync ? bus.phase : phase_q;
        pe       = (phaseSel > LAST) ? LAST : phaseSel;
        keep     = (idx == pe);

        cnt_d   = cnt_q;
        phase_d = bus.sync ? bus.phase : phase_q;
        data_d  = data_q;
        valid_d = 1'b0;
        zero_d  = 1'b0;
        ready_d = ready_q;
        err_d   = err_q;

        if (bus.en) begin
            cnt_d = (idx == LAST) ? 4'd0 : idx + 4'd1;
            if (keep) begin
                data_d  = bus.data_in;
                valid_d = 1'b1;
                ready_d = 1'b1;
            end else if (bus.data_in != '0) begin
                zero_d = 1'b1;
                if (err_q != 8'hFF) begin
                    err_d = err_q + 8'd1;
                end
            end
        end else if (bus.sync) begin
            cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.ready     = ready_q;
    assign bus.zero_err  = zero_q;
    assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_sample_decimator.sv
// Bench for sample_decimator: directed scenarios plus a randomized run,
// each compared against a sample-count reference model.
module tb_sample_decimator;
    localparam int WD     = 16;
    localparam int FACTOR = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sample_decimator_if #(.width_data(WD)) bus ();

    sample_decimator #(.width_data(WD), .factor(FACTOR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: samples seen since the last sync, taken modulo factor.
    logic [WD-1:0] expData  = '0;
    logic          expValid = 1'b0;
    logic          expReady = 1'b0;
    logic          expZero  = 1'b0;
    int            expErr   = 0;
    int            sinceSync = 0;
    int            mPhase    = 0;
    int            cycle     = 0;

    task automatic modelStep(input logic r, input logic e, input logic s,
                             input logic [3:0] p, input logic [WD-1:0] d);
        int idx, ph, pe;
        if (r) begin
            expData = '0; expValid = 0; expReady = 0; expZero = 0; expErr = 0;
            sinceSync = 0; mPhase = 0;
        end else begin
            idx = s ? 0 : (sinceSync % FACTOR);
            ph  = s ? int'(p) : mPhase;
            pe  = (ph < FACTOR) ? ph : FACTOR - 1;
            expValid = 0;
            expZero  = 0;
            if (e) begin
                if (idx == pe) begin
                    expData = d; expValid = 1; expReady = 1;
                end else if (d != 0) begin
                    expZero = 1;
                    if (expErr < 255) expErr++;
                end
                sinceSync = s ? 1 : sinceSync + 1;
            end else if (s) begin
                sinceSync = 0;
            end
            if (s) mPhase = int'(p);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic s,
                         input logic [3:0] p, input logic [WD-1:0] d);
        @(negedge clk);
        rst = r; bus.en = e; bus.sync = s; bus.phase = p; bus.data_in = d;
        @(posedge clk);
        modelStep(r, e, s, p, d);
        cycle++;
        #1;
    endtask

    task automatic test_reset;
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 16'h1111);
        checks++;
        if (bus.data_out !== '0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", bus.data_out); end
        checks++;
        if (bus.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", bus.valid_out); end
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b want 0", bus.ready); end
        checks++;
        if (bus.zero_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_zero_err got %b want 0", bus.zero_err); end
        checks++;
        if (bus.err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_err_cnt got %0d want 0", bus.err_cnt); end
    endtask

    task automatic test_continuous;
        int kept[$];
        drive(1, 0, 0, 0, 0);
        for (int v = 1; v <= 12; v++) begin
            drive(0, 1, (v == 1), 0, WD'(v));
            if (bus.valid_out === 1'b1) kept.push_back(int'(bus.data_out));
            checks++;
            if (bus.valid_out !== expValid || bus.data_out !== expData) begin
                errors++;
                $display("[TB] FAIL cont_sample%0d got v=%b d=%h want v=%b d=%h",
                         v, bus.valid_out, bus.data_out, expValid, expData);
            end
            if (v == 1) begin
                checks++;
                if (bus.ready !== 1'b1 || bus.valid_out !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL cont_ready_first got r=%b v=%b want 1 1", bus.ready, bus.valid_out);
                end
            end
        end
        checks++;
        if (kept.size() != 3 || kept[0] != 1 || kept[1] != 5 || kept[2] != 9) begin
            errors++;
            $display("[TB] FAIL cont_kept got %p want '{1,5,9}", kept);
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (bus.data_out !== 16'd9 || bus.valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cont_hold got d=%0d v=%b want 9 0", bus.data_out, bus.valid_out);
        end
    endtask

    task automatic test_clean_stream;
        logic [WD-1:0] seq [8] = '{16'h1234, 0, 0, 0, 16'h8001, 0, 0, 0};
        int kept[$];
        int zeroSeen = 0;
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, (i == 0), 0, seq[i]);
            if (bus.valid_out === 1'b1) kept.push_back(int'(bus.data_out));
            if (bus.zero_err !== 1'b0) zeroSeen++;
        end
        checks++;
        if (kept.size() != 2 || kept[0] != 'h1234 || kept[1] != 'h8001) begin
            errors++;
            $display("[TB] FAIL clean_kept got %p want '{4660,32769}", kept);
        end
        checks++;
        if (zeroSeen != 0 || bus.err_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL clean_no_err got pulses=%0d cnt=%0d want 0 0", zeroSeen, bus.err_cnt);
        end
    endtask

    task automatic test_phase_select;
        int kept[$];
        drive(0, 1, 1, 2, 16'd10);
        for (int v = 11; v <= 17; v++) begin
            drive(0, 1, 0, 2, WD'(v));
            if (bus.valid_out === 1'b1) kept.push_back(int'(bus.data_out));
        end
        checks++;
        if (kept.size() != 2 || kept[0] != 12 || kept[1] != 16) begin
            errors++;
            $display("[TB] FAIL phase2_kept got %p want '{12,16}", kept);
        end
        kept.delete();
        for (int v = 18; v <= 25; v++) begin
            drive(0, 1, 0, 1, WD'(v));
            if (bus.valid_out === 1'b1) kept.push_back(int'(bus.data_out));
        end
        checks++;
        if (kept.size() != 2 || kept[0] != 20 || kept[1] != 24) begin
            errors++;
            $display("[TB] FAIL phase_nosync_kept got %p want '{20,24}", kept);
        end
        kept.delete();
        drive(0, 1, 1, 9, 16'd30);
        for (int v = 31; v <= 37; v++) begin
            drive(0, 1, 0, 9, WD'(v));
            if (bus.valid_out === 1'b1) kept.push_back(int'(bus.data_out));
        end
        checks++;
        if (kept.size() != 2 || kept[0] != 33 || kept[1] != 37) begin
            errors++;
            $display("[TB] FAIL phase9_clamp_kept got %p want '{33,37}", kept);
        end
    endtask

    task automatic test_en_gaps;
        logic [WD-1:0] seq [8] = '{16'h0005, 0, 0, 0, 16'h0006, 0, 0, 0};
        int kept[$];
        int when[$];
        int zeroSeen = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, (i == 0), 0, seq[i]);
            if (bus.valid_out === 1'b1) begin kept.push_back(int'(bus.data_out)); when.push_back(cycle); end
            if (bus.zero_err !== 1'b0) zeroSeen++;
            for (int g = 0; g < 2; g++) begin
                drive(0, 0, 0, 0, 16'hFFFF);
                if (bus.valid_out !== 1'b0) kept.push_back(-1);
                if (bus.zero_err !== 1'b0) zeroSeen++;
            end
        end
        checks++;
        if (kept.size() != 2 || kept[0] != 5 || kept[1] != 6) begin
            errors++;
            $display("[TB] FAIL gaps_kept got %p want '{5,6}", kept);
        end
        checks++;
        if (when.size() != 2 || when[1] - when[0] != 12) begin
            errors++;
            $display("[TB] FAIL gaps_spacing got %p want 12 apart", when);
        end
        checks++;
        if (zeroSeen != 0) begin
            errors++;
            $display("[TB] FAIL gaps_zero_err got %0d pulses want 0", zeroSeen);
        end
    endtask

    task automatic test_error_count;
        int pulses = 0;
        int bad = 0;
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            drive(0, 1, (i == 0), 0, 16'h7FFF);
            if (bus.zero_err === 1'b1) pulses++;
            if (bus.zero_err !== expZero || int'(bus.err_cnt) != expErr) bad++;
        end
        checks++;
        if (pulses != 300) begin
            errors++;
            $display("[TB] FAIL err_pulses got %0d want 300", pulses);
        end
        checks++;
        if (bus.err_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL err_saturate got %0d want 255", bus.err_cnt);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL err_track got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_reset_mid;
        drive(0, 1, 1, 2, 16'h0000);
        drive(0, 1, 0, 2, 16'h0000);
        drive(1, 1, 0, 2, 16'h0022);
        checks++;
        if ({bus.data_out, bus.valid_out, bus.ready, bus.zero_err, bus.err_cnt} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_zero got d=%h v=%b r=%b z=%b c=%0d want all 0",
                     bus.data_out, bus.valid_out, bus.ready, bus.zero_err, bus.err_cnt);
        end
        drive(0, 1, 0, 2, 16'h00AA);
        checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 16'h00AA || bus.ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_keep got v=%b d=%h r=%b want 1 00aa 1",
                     bus.valid_out, bus.data_out, bus.ready);
        end
    endtask

    task automatic test_random;
        logic          r, e, s;
        logic [3:0]    p;
        logic [WD-1:0] d;
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 15) == 0);
            p = 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 1) == 0) ? '0 : WD'($urandom);
            drive(r, e, s, p, d);
            checks++;
            if (bus.data_out !== expData || bus.valid_out !== expValid || bus.ready !== expReady ||
                bus.zero_err !== expZero || int'(bus.err_cnt) != expErr) begin
                errors++;
                $display("[TB] FAIL rand_cycle%0d got d=%h v=%b r=%b z=%b c=%0d want d=%h v=%b r=%b z=%b c=%0d",
                         i, bus.data_out, bus.valid_out, bus.ready, bus.zero_err, bus.err_cnt,
                         expData, expValid, expReady, expZero, expErr);
            end
        end
    endtask

    initial begin
        bus.en = 0; bus.sync = 0; bus.phase = 0; bus.data_in = 0;
        test_reset();
        test_continuous();
        test_clean_stream();
        test_phase_select();
        test_en_gaps();
        test_error_count();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
